// File: rtl/do_unpad_serializer.sv
// rtl/do_unpad_serializer.sv - unmasks a 128-bit two-share block and streams it out as BUSW-bit words
// Trailing bytes beyond the valid length are zeroed; a zero-length partial block produces no words.
module do_unpad_serializer #(
  parameter int BUSW = 32,
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            blk_valid,
  output logic            blk_ready,
  input  logic [127:0]    blk_s0,
  input  logic [127:0]    blk_s1,
  input  logic            blk_partial,
  input  logic [3:0]      blk_seglen,
  input  logic            blk_last,
  output logic [BUSW-1:0] do_data,
  output logic            do_valid,
  input  logic            do_ready,
  output logic            do_last,
  output logic            busy
);

  localparam int BPW = BUSW / 8;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [127:0]    buf_q, buf_d;
  logic            partial_q, partial_d;
  logic [3:0]      seglen_q, seglen_d;
  logic            last_q, last_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [4:0]      nbytes_in;
  logic [4:0]      nbytes;
  logic [5:0]      nwords;
  logic            at_last_word;
  logic            final_word;
  logic [7:0]      shamt;
  logic [127:0]    shifted;
  logic [7:0]      gidx;

  assign nbytes_in = blk_partial ? {1'b0, blk_seglen} : 5'd16;
  assign nbytes    = partial_q ? {1'b0, seglen_q} : 5'd16;
  assign nwords    = (6'(nbytes) + 6'(BPW - 1)) / 6'(BPW);

  assign at_last_word = (6'(cnt_q) == nwords - 6'd1);
  // The all-ones counter check keeps cnt from ever wrapping inside a block.
  assign final_word   = at_last_word || (cnt_q == {CNTW{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      partial_q <= 1'b0;
      seglen_q  <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      partial_q <= partial_d;
      seglen_q  <= seglen_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    partial_d = partial_q;
    seglen_d  = seglen_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          buf_d     = blk_s0 ^ blk_s1;
          partial_d = blk_partial;
          seglen_d  = blk_seglen;
          last_d    = blk_last;
          cnt_d     = '0;
          if (nbytes_in != 5'd0) state_d = SEND;
        end
      end
      SEND: begin
        if (do_ready) begin
          if (final_word) state_d = IDLE;
          else            cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign shamt   = 8'(cnt_q) * 8'(BUSW);
  assign shifted = buf_q << shamt;

  // Byte-wise masking: anything at or past the valid length reads as zero.
  always_comb begin
    do_data = '0;
    gidx    = '0;
    if (state_q == SEND) begin
      for (int b = 0; b < BPW; b++) begin
        gidx = 8'(cnt_q) * 8'(BPW) + 8'(b);
        if (gidx < {3'b000, nbytes})
          do_data[BUSW-1-8*b -: 8] = shifted[127-8*b -: 8];
      end
    end
  end

  assign blk_ready = (state_q == IDLE);
  assign do_valid  = (state_q == SEND);
  assign busy      = (state_q == SEND);
  assign do_last   = (state_q == SEND) && at_last_word && last_q;

endmodule

// File: tb/tb_do_unpad_serializer.sv
// tb/tb_do_unpad_serializer.sv - scoreboard bench for do_unpad_serializer
module tb_do_unpad_serializer;

  localparam int BUSW = 32;
  localparam int CNTW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            blk_valid;
  logic            blk_ready;
  logic [127:0]    blk_s0, blk_s1;
  logic            blk_partial;
  logic [3:0]      blk_seglen;
  logic            blk_last;
  logic [BUSW-1:0] do_data;
  logic            do_valid;
  logic            do_ready;
  logic            do_last;
  logic            busy;

  int total = 0;
  int bad   = 0;
  int popped = 0;
  int ready_mode = 0;
  int cyc = 0;

  logic [BUSW:0] exp_q[$];

  do_unpad_serializer #(.BUSW(BUSW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_s0(blk_s0), .blk_s1(blk_s1),
    .blk_partial(blk_partial), .blk_seglen(blk_seglen), .blk_last(blk_last),
    .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready),
    .do_last(do_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] byteval(input logic [127:0] blk, input int idx);
    return {120'b0, blk[127-8*idx -: 8]};
  endfunction

  task automatic push_model(input logic [127:0] blk, input logic partial,
                            input logic [3:0] seglen, input logic last);
    int nb, nw;
    logic [BUSW-1:0] w;
    nb = partial ? int'(seglen) : 16;
    nw = (nb + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        int idx;
        idx = k * 4 + b;
        if (idx < nb) w[31-8*b -: 8] = byteval(blk, idx)[7:0];
      end
      exp_q.push_back({(last && k == nw - 1), w});
    end
  endtask

  // Drive point is #1 after a rising edge.
  task automatic offer(input logic [127:0] s0, input logic [127:0] s1, input logic partial,
                       input logic [3:0] seglen, input logic last);
    int n;
    n = 0;
    while (!blk_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("offer_ready_timeout", {63'b0, blk_ready}, 64'd1);
    blk_valid   = 1'b1;
    blk_s0      = s0;
    blk_s1      = s1;
    blk_partial = partial;
    blk_seglen  = seglen;
    blk_last    = last;
    @(posedge clk); #1;
    blk_valid   = 1'b0;
    blk_s0      = {$urandom, $urandom, $urandom, $urandom};
    blk_s1      = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || do_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", {63'b0, (n >= 300)}, 64'd0);
    exp_q.delete();
  endtask

  // do_ready source: always high, or the 1,0,0,1 stall pattern.
  initial begin
    do_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (ready_mode == 0) do_ready = 1'b1;
      else                 do_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_valid", {63'b0, busy}, {63'b0, do_valid});
      if (!do_valid) begin
        check("idle_data_zero", {32'b0, do_data}, 64'd0);
      end else if (exp_q.size() == 0) begin
        check("extra_word", {63'b0, do_valid}, 64'd0);
      end else begin
        check("word_data", {32'b0, do_data}, {32'b0, exp_q[0][BUSW-1:0]});
        check("word_last", {63'b0, do_last}, {63'b0, exp_q[0][BUSW]});
        if (do_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  localparam logic [127:0] S0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] M1 = 128'hFFFFFFFF_00000000_00000000_00000000;

  initial begin
    int n;
    rst = 1'b1; blk_valid = 1'b0; blk_s0 = '0; blk_s1 = '0;
    blk_partial = 1'b0; blk_seglen = '0; blk_last = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_blk_ready", {63'b0, blk_ready}, 64'd1);
    check("rst_do_valid", {63'b0, do_valid}, 64'd0);
    check("rst_do_data", {32'b0, do_data}, 64'd0);
    check("rst_do_last", {63'b0, do_last}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);

    // Full block, consecutive words.
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b0, 32'h44556677});
    exp_q.push_back({1'b0, 32'h8899AABB});
    exp_q.push_back({1'b1, 32'hCCDDEEFF});
    offer(S0, '0, 1'b0, 4'd0, 1'b1);
    n = popped;
    repeat (4) @(posedge clk);
    #1;
    check("full_4_consecutive", popped - n, 64'd4);
    drain();

    // Masked shares give the same unmasked output.
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b0, 32'h44556677});
    exp_q.push_back({1'b0, 32'h8899AABB});
    exp_q.push_back({1'b1, 32'hCCDDEEFF});
    offer(S0 ^ M1, M1, 1'b0, 4'd0, 1'b1);
    drain();

    // Partial, 5 bytes.
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b1, 32'h44000000});
    offer(S0, '0, 1'b1, 4'd5, 1'b1);
    drain();
    check("seg5_back_idle", {63'b0, blk_ready}, 64'd1);

    // Zero-length partial: accepted, no words.
    offer(S0, '0, 1'b1, 4'd0, 1'b1);
    check("seg0_ready", {63'b0, blk_ready}, 64'd1);
    check("seg0_no_valid", {63'b0, do_valid}, 64'd0);

    // Partial, 15 bytes, not last.
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b0, 32'h44556677});
    exp_q.push_back({1'b0, 32'h8899AABB});
    exp_q.push_back({1'b0, 32'hCCDDEE00});
    offer(S0, '0, 1'b1, 4'd15, 1'b0);
    drain();

    // Random blocks, back-to-back, with and without stalls.
    for (int t = 0; t < 12; t++) begin
      logic [127:0] a, m;
      logic p, l;
      logic [3:0] s;
      a = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      p = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      l = 1'($urandom_range(0, 1));
      ready_mode = t % 2;
      push_model(a, p, s, l);
      offer(a ^ m, m, p, s, l);
    end
    drain();

    // Stall pattern, reset after word 2.
    ready_mode = 1;
    push_model(S0, 1'b0, 4'd0, 1'b1);
    n = popped;
    offer(S0, '0, 1'b0, 4'd0, 1'b1);
    begin
      int k;
      k = 0;
      while (popped - n < 2 && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("stall_reach_word2", {63'b0, (popped - n >= 2)}, 64'd1);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_do_valid", {63'b0, do_valid}, 64'd0);
    check("midrst_blk_ready", {63'b0, blk_ready}, 64'd1);
    check("midrst_do_data", {32'b0, do_data}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_stays_idle", {63'b0, do_valid}, 64'd0);

    // New block after reset starts at word 0.
    ready_mode = 0;
    push_model(S0, 1'b0, 4'd0, 1'b1);
    offer(S0, '0, 1'b0, 4'd0, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/do_unpad_serializer.md
DO_UNPAD_SERIALIZER -- requirements
Module: do_unpad_serializer

Interface
REQ-001 The module SHALL have parameter BUSW, default 32, meaning data-out word width in bits (multiple of 8, divides 128).
REQ-002 The module SHALL have parameter CNTW, default 2, meaning word-counter width; 2**CNTW = 128/BUSW.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The module SHALL have port blk_valid, input, 1, meaning an output block is offered.
REQ-006 The module SHALL have port blk_ready, output, 1, meaning a block is accepted when high together with blk_valid.
REQ-007 The module SHALL have port blk_s0, input, 128, meaning block share 0; byte 0 = bits [127:120].
REQ-008 The module SHALL have port blk_s1, input, 128, meaning block share 1, same byte order.
REQ-009 The module SHALL have port blk_partial, input, 1, meaning the block is a truncated final segment.
REQ-010 The module SHALL have port blk_seglen, input, 4, meaning the valid byte count when blk_partial=1.
REQ-011 The module SHALL have port blk_last, input, 1, meaning the block ends the message.
REQ-012 The module SHALL have port do_data, output, BUSW, meaning the unmasked, truncated output word.
REQ-013 The module SHALL have port do_valid, output, 1, meaning do_data is valid.
REQ-014 The module SHALL have port do_ready, input, 1, meaning the consumer accepts do_data when high with do_valid.
REQ-015 The module SHALL have port do_last, output, 1, meaning the current word is the final word of the message.
REQ-016 The module SHALL have port busy, output, 1, meaning a block is held (state SEND).

Function
REQ-017 The FSM SHALL have two states: IDLE (blk_ready=1, do_valid=0) and SEND (blk_ready=0, do_valid=1).
REQ-018 IDLE with blk_valid=1 SHALL register blk_s0^blk_s1 into a 128-bit unmasked buffer, plus partial, seglen and last, clear cnt to 0, and go to SEND if nbytes>0.
REQ-019 nbytes SHALL be 16 when blk_partial=0, else blk_seglen (0..15).
REQ-020 Partial with seglen=0 (nbytes=0) SHALL be accepted, emit no word, and stay in IDLE.
REQ-021 nwords SHALL be ceil(nbytes*8/BUSW); at BUSW=32: 1-4 bytes -> 1 word, 5-8 -> 2, 9-12 -> 3, 13-16 -> 4.
REQ-022 In SEND, do_data SHALL equal buffer bytes [cnt*BUSW/8 .. cnt*BUSW/8+BUSW/8-1], byte 0 of the slice in the MSBs.
REQ-023 Any byte with global index >= nbytes SHALL be driven 8'h00 on do_data; no padding or length byte is emitted.
REQ-024 do_data SHALL be 0 whenever do_valid=0.
REQ-025 do_last SHALL be 1 only when do_valid=1, cnt=nwords-1 and the stored last flag=1.
REQ-026 do_valid/do_data/do_last SHALL stay stable until do_valid & do_ready; cnt increments by 1 on each such handshake.
REQ-027 A handshake at cnt=nwords-1 SHALL return the FSM to IDLE on the next edge; the next block is accepted no earlier than one cycle after that handshake.
REQ-028 cnt SHALL never wrap inside a block; cnt=2**CNTW-1 handshake ends the block.
REQ-029 blk_valid while in SEND SHALL be ignored; blk_s0/blk_s1 changes in SEND SHALL not affect do_data.
REQ-030 do_ready held low SHALL stall indefinitely with no state change.
REQ-031 busy SHALL be 1 exactly when state=SEND.

Reset
REQ-032 rst=1 at a rising edge SHALL force IDLE, cnt=0, buffer=0, stored flags=0, regardless of current state, including mid-block.
REQ-033 After reset: blk_ready=1, do_valid=0, do_data=0, do_last=0, busy=0; a block interrupted by reset is discarded with no further words.

Verification
REQ-034 Full block, s0=0x00112233_44556677_8899AABB_CCDDEEFF, s1=0, partial=0, last=1, do_ready=1 -> words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles, do_last only on 4th.
REQ-035 Same s0, s1=0xFFFFFFFF_00000000_00000000_00000000, then s0^=s1 inputs -> identical unmasked output as REQ-034.
REQ-036 Partial, seglen=5, last=1 -> exactly 2 words: 0x00112233, then 0x44000000 with do_last=1; back to IDLE.
REQ-037 Partial, seglen=0 -> no do_valid, blk_ready high the following cycle; seglen=15 -> 4 words, last 0xCCDDEE00.
REQ-038 Full block, do_ready toggled 1,0,0,1,... -> each word held while stalled, no duplicates or skips; rst asserted after word 2 -> do_valid=0, blk_ready=1 next cycle, new block starts at word 0.
